alu_decode_stage: RTL and testbench

Decode and ID/EX pipeline stage that produces the `ALUCode`, `A` and `B` operands consumed by the execute-stage ALU, plus writeback and memory control. It maps a 32-bit MIPS instruction and the register-file read data to the ALU's 5-bit operation code and operand pair. The result is registered once per cycle, with stall (hold) and flush (bubble) control from the hazard unit. It sits between the register file and the EX stage.

---
 rtl/alu_decode_stage_if.sv | 33 +++
 rtl/alu_decode_stage.sv | 155 +++++++++++++++
 tb/tb_alu_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_stage_if.sv
// ID-to-EX bundle of the ALU decode stage: ID payload plus hazard controls in, EX register contents out.
// Valid_id qualifies the ID payload; there is no ready, Stall is the backpressure and the payload is held upstream while it is high.
interface alu_decode_stage_if;
    logic [31:0] Instruction_id;
    logic        Valid_id;
    logic [31:0] RsData_id;
    logic [31:0] RtData_id;
    logic        Stall;
    logic        Flush;

    logic [4:0]  ALUCode_ex;
    logic [31:0] A_ex;
    logic [31:0] B_ex;
    logic [31:0] RtData_ex;
    logic [4:0]  WriteReg_ex;
    logic        RegWrite_ex;
    logic        MemRead_ex;
    logic        MemWrite_ex;
    logic        Valid_ex;
    logic        Illegal_ex;

    modport master (
        output Instruction_id, Valid_id, RsData_id, RtData_id, Stall, Flush,
        input  ALUCode_ex, A_ex, B_ex, RtData_ex, WriteReg_ex,
        input  RegWrite_ex, MemRead_ex, MemWrite_ex, Valid_ex, Illegal_ex
    );

    modport slave (
        input  Instruction_id, Valid_id, RsData_id, RtData_id, Stall, Flush,
        output ALUCode_ex, A_ex, B_ex, RtData_ex, WriteReg_ex,
        output RegWrite_ex, MemRead_ex, MemWrite_ex, Valid_ex, Illegal_ex
    );
endinterface

// File: rtl/alu_decode_stage.sv
// MIPS decode plus ID/EX register: turns an instruction and register-file data into ALU code, operands
// and writeback/memory control, with flush-over-stall priority and asynchronous active-low reset.
module alu_decode_stage (
    input  logic              clk,
    input  logic              rst_n,
    alu_decode_stage_if.slave bus
);

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000, ALU_AND  = 5'b00001, ALU_XOR  = 5'b00010, ALU_OR   = 5'b00011,
        ALU_NOR  = 5'b00100, ALU_SUB  = 5'b00101, ALU_ANDI = 5'b00110, ALU_XORI = 5'b00111,
        ALU_ORI  = 5'b01000, ALU_JR   = 5'b01001, ALU_BEQ  = 5'b01010, ALU_BNE  = 5'b01011,
        ALU_BGEZ = 5'b01100, ALU_BGTZ = 5'b01101, ALU_BLEZ = 5'b01110, ALU_BLTZ = 5'b01111,
        ALU_SLL  = 5'b10000, ALU_SRL  = 5'b10001, ALU_SRA  = 5'b10010, ALU_SLT  = 5'b10011,
        ALU_SLTU = 5'b10100
    } alu_code_e;

    typedef struct packed {
        logic [4:0]  alu_code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rt_data;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        valid;
        logic        illegal;
    } ex_t;

    // All-zero record doubles as the bubble and the reset value (ALUCode 00000 = add).
    localparam ex_t BUBBLE = '0;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] sext_imm, zext_imm;

    assign op       = bus.Instruction_id[31:26];
    assign rs       = bus.Instruction_id[25:21];
    assign rt       = bus.Instruction_id[20:16];
    assign rd       = bus.Instruction_id[15:11];
    assign sh       = bus.Instruction_id[10:6];
    assign fn       = bus.Instruction_id[5:0];
    assign imm      = bus.Instruction_id[15:0];
    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'b0, imm};

    alu_code_e   dec_alu;
    logic [31:0] dec_a, dec_b;
    logic        dec_write, dec_use_rd, dec_mem_read, dec_mem_write, dec_illegal;

    always_comb begin
        dec_alu       = ALU_ADD;
        dec_a         = bus.RsData_id;
        dec_b         = 32'd0;
        dec_write     = 1'b0;
        dec_use_rd    = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_illegal   = 1'b0;
        case (op)
            6'h00: begin
                dec_b      = bus.RtData_id;
                dec_write  = 1'b1;
                dec_use_rd = 1'b1;
                case (fn)
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h22, 6'h23: dec_alu = ALU_SUB;
                    6'h24:        dec_alu = ALU_AND;
                    6'h25:        dec_alu = ALU_OR;
                    6'h26:        dec_alu = ALU_XOR;
                    6'h27:        dec_alu = ALU_NOR;
                    6'h2A:        dec_alu = ALU_SLT;
                    6'h2B:        dec_alu = ALU_SLTU;
                    6'h00: begin dec_alu = ALU_SLL; dec_a = {27'b0, sh}; end
                    6'h02: begin dec_alu = ALU_SRL; dec_a = {27'b0, sh}; end
                    6'h03: begin dec_alu = ALU_SRA; dec_a = {27'b0, sh}; end
                    6'h04: begin dec_alu = ALU_SLL; dec_a = {27'b0, bus.RsData_id[4:0]}; end
                    6'h06: begin dec_alu = ALU_SRL; dec_a = {27'b0, bus.RsData_id[4:0]}; end
                    6'h07: begin dec_alu = ALU_SRA; dec_a = {27'b0, bus.RsData_id[4:0]}; end
                    6'h08: begin dec_alu = ALU_JR; dec_b = 32'd0; dec_write = 1'b0; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h01: begin
                if (rt == 5'd1)      dec_alu = ALU_BGEZ;
                else if (rt == 5'd0) dec_alu = ALU_BLTZ;
                else                 dec_illegal = 1'b1;
            end
            6'h04: begin dec_alu = ALU_BEQ; dec_b = bus.RtData_id; end
            6'h05: begin dec_alu = ALU_BNE; dec_b = bus.RtData_id; end
            6'h06: dec_alu = ALU_BLEZ;
            6'h07: dec_alu = ALU_BGTZ;
            6'h08, 6'h09: begin dec_alu = ALU_ADD;  dec_b = sext_imm; dec_write = 1'b1; end
            6'h0A:        begin dec_alu = ALU_SLT;  dec_b = sext_imm; dec_write = 1'b1; end
            6'h0B:        begin dec_alu = ALU_SLTU; dec_b = sext_imm; dec_write = 1'b1; end
            6'h0C:        begin dec_alu = ALU_ANDI; dec_b = zext_imm; dec_write = 1'b1; end
            6'h0D:        begin dec_alu = ALU_ORI;  dec_b = zext_imm; dec_write = 1'b1; end
            6'h0E:        begin dec_alu = ALU_XORI; dec_b = zext_imm; dec_write = 1'b1; end
            6'h0F: begin
                // lui is executed as a shift of the zero-extended immediate left by 16.
                dec_alu   = ALU_SLL;
                dec_a     = 32'd16;
                dec_b     = zext_imm;
                dec_write = 1'b1;
            end
            6'h23: begin dec_alu = ALU_ADD; dec_b = sext_imm; dec_write = 1'b1; dec_mem_read = 1'b1; end
            6'h2B: begin dec_alu = ALU_ADD; dec_b = sext_imm; dec_mem_write = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [4:0] dest;
    assign dest = dec_use_rd ? rd : rt;

    ex_t ex_d, ex_q;

    always_comb begin
        ex_d = BUBBLE;
        if (bus.Valid_id) begin
            ex_d.valid = 1'b1;
            if (dec_illegal) begin
                ex_d.illegal = 1'b1;
            end else begin
                ex_d.alu_code  = dec_alu;
                ex_d.a         = dec_a;
                ex_d.b         = dec_b;
                ex_d.rt_data   = bus.RtData_id;
                ex_d.reg_write = dec_write && (dest != 5'd0);
                ex_d.write_reg = (dec_write && (dest != 5'd0)) ? dest : 5'd0;
                ex_d.mem_read  = dec_mem_read;
                ex_d.mem_write = dec_mem_write;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ex_q <= BUBBLE;
        else if (bus.Flush)  ex_q <= BUBBLE;
        else if (!bus.Stall) ex_q <= ex_d;
    end

    assign bus.ALUCode_ex  = ex_q.alu_code;
    assign bus.A_ex        = ex_q.a;
    assign bus.B_ex        = ex_q.b;
    assign bus.RtData_ex   = ex_q.rt_data;
    assign bus.WriteReg_ex = ex_q.write_reg;
    assign bus.RegWrite_ex = ex_q.reg_write;
    assign bus.MemRead_ex  = ex_q.mem_read;
    assign bus.MemWrite_ex = ex_q.mem_write;
    assign bus.Valid_ex    = ex_q.valid;
    assign bus.Illegal_ex  = ex_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vector table, hand-written reset/stall/flush sequences,
// then randomized traffic checked against a rule-table reference model.
module tb_alu_decode_stage;

    logic clk;
    logic rst_n;
    alu_decode_stage_if bus ();

    alu_decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rtd;
        logic [4:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        valid;
        logic        ill;
    } exp_t;

    // asel: 0 Rs, 1 shamt, 2 Rs[4:0], 3 constant 16 ; bsel: 0 Rt, 1 sext imm, 2 zext imm, 3 zero
    typedef struct {
        int code;
        int asel;
        int bsel;
        bit wr;
        bit rd_dest;
        bit mr;
        bit mw;
    } rule_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
    } vec_t;

    rule_t r_rules[int];
    rule_t i_rules[int];
    logic [110:0] exp_q[$];
    int tests;
    int failed;

    function automatic rule_t mk(int code, int asel, int bsel, bit wr, bit rd_dest, bit mr, bit mw);
        rule_t r;
        r.code = code; r.asel = asel; r.bsel = bsel; r.wr = wr;
        r.rd_dest = rd_dest; r.mr = mr; r.mw = mw;
        return r;
    endfunction

    function automatic exp_t mkexp(logic [4:0] alu, logic [31:0] a, logic [31:0] b, logic [31:0] rtd,
                                   logic [4:0] wreg, logic rw, logic mr, logic mw, logic ill);
        exp_t e;
        e.alu = alu; e.a = a; e.b = b; e.rtd = rtd; e.wreg = wreg;
        e.rw = rw; e.mr = mr; e.mw = mw; e.valid = 1'b1; e.ill = ill;
        return e;
    endfunction

    task automatic build_rules();
        r_rules[32'h20] = mk(0, 0, 0, 1, 1, 0, 0);  r_rules[32'h21] = mk(0, 0, 0, 1, 1, 0, 0);
        r_rules[32'h22] = mk(5, 0, 0, 1, 1, 0, 0);  r_rules[32'h23] = mk(5, 0, 0, 1, 1, 0, 0);
        r_rules[32'h24] = mk(1, 0, 0, 1, 1, 0, 0);  r_rules[32'h25] = mk(3, 0, 0, 1, 1, 0, 0);
        r_rules[32'h26] = mk(2, 0, 0, 1, 1, 0, 0);  r_rules[32'h27] = mk(4, 0, 0, 1, 1, 0, 0);
        r_rules[32'h2A] = mk(19, 0, 0, 1, 1, 0, 0); r_rules[32'h2B] = mk(20, 0, 0, 1, 1, 0, 0);
        r_rules[32'h00] = mk(16, 1, 0, 1, 1, 0, 0); r_rules[32'h02] = mk(17, 1, 0, 1, 1, 0, 0);
        r_rules[32'h03] = mk(18, 1, 0, 1, 1, 0, 0); r_rules[32'h04] = mk(16, 2, 0, 1, 1, 0, 0);
        r_rules[32'h06] = mk(17, 2, 0, 1, 1, 0, 0); r_rules[32'h07] = mk(18, 2, 0, 1, 1, 0, 0);
        r_rules[32'h08] = mk(9, 0, 3, 0, 1, 0, 0);
        i_rules[32'h08] = mk(0, 0, 1, 1, 0, 0, 0);  i_rules[32'h09] = mk(0, 0, 1, 1, 0, 0, 0);
        i_rules[32'h0A] = mk(19, 0, 1, 1, 0, 0, 0); i_rules[32'h0B] = mk(20, 0, 1, 1, 0, 0, 0);
        i_rules[32'h0C] = mk(6, 0, 2, 1, 0, 0, 0);  i_rules[32'h0D] = mk(8, 0, 2, 1, 0, 0, 0);
        i_rules[32'h0E] = mk(7, 0, 2, 1, 0, 0, 0);  i_rules[32'h0F] = mk(16, 3, 2, 1, 0, 0, 0);
        i_rules[32'h23] = mk(0, 0, 1, 1, 0, 1, 0);  i_rules[32'h2B] = mk(0, 0, 1, 0, 0, 0, 1);
        i_rules[32'h04] = mk(10, 0, 0, 0, 0, 0, 0); i_rules[32'h05] = mk(11, 0, 0, 0, 0, 0, 0);
        i_rules[32'h06] = mk(14, 0, 3, 0, 0, 0, 0); i_rules[32'h07] = mk(13, 0, 3, 0, 0, 0, 0);
    endtask

    function automatic exp_t model(logic [31:0] ins, logic v, logic [31:0] rsd, logic [31:0] rtd);
        exp_t  e;
        rule_t r;
        bit    found;
        int    op, fn, rt, rd, sh, dest;
        logic [15:0] imm;
        e = '0;
        found = 0;
        op = int'(ins[31:26]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        sh = int'(ins[10:6]);  fn = int'(ins[5:0]);   imm = ins[15:0];
        if (!v) return e;
        e.valid = 1'b1;
        if (op == 0) begin
            if (r_rules.exists(fn)) begin r = r_rules[fn]; found = 1; end
        end else if (op == 1) begin
            if (rt == 1)      begin r = mk(12, 0, 3, 0, 0, 0, 0); found = 1; end
            else if (rt == 0) begin r = mk(15, 0, 3, 0, 0, 0, 0); found = 1; end
        end else if (i_rules.exists(op)) begin
            r = i_rules[op]; found = 1;
        end
        if (!found) begin
            e.ill = 1'b1;
            return e;
        end
        e.alu = 5'(r.code);
        case (r.asel)
            0:       e.a = rsd;
            1:       e.a = 32'(sh);
            2:       e.a = rsd % 32;
            default: e.a = 32'd16;
        endcase
        case (r.bsel)
            0:       e.b = rtd;
            1:       e.b = 32'($signed(imm));
            2:       e.b = 32'(imm);
            default: e.b = 32'd0;
        endcase
        dest = r.rd_dest ? rd : rt;
        if (r.wr && dest != 0) begin
            e.rw = 1'b1;
            e.wreg = 5'(dest);
        end
        e.mr = r.mr;
        e.mw = r.mw;
        e.rtd = rtd;
        return e;
    endfunction

    task automatic drive(logic [31:0] ins, logic v, logic [31:0] rs, logic [31:0] rt, logic stall, logic flush);
        bus.Instruction_id = ins;
        bus.Valid_id       = v;
        bus.RsData_id      = rs;
        bus.RtData_id      = rt;
        bus.Stall          = stall;
        bus.Flush          = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, exp_t e);
        exp_t act;
        act = {bus.ALUCode_ex, bus.A_ex, bus.B_ex, bus.RtData_ex, bus.WriteReg_ex,
               bus.RegWrite_ex, bus.MemRead_ex, bus.MemWrite_ex, bus.Valid_ex, bus.Illegal_ex};
        tests++;
        if (act !== e) begin
            failed++;
            $display("FAIL %s: got alu=%h a=%h b=%h rtd=%h wreg=%0d rw=%b mr=%b mw=%b v=%b ill=%b | want alu=%h a=%h b=%h rtd=%h wreg=%0d rw=%b mr=%b mw=%b v=%b ill=%b",
                     name, act.alu, act.a, act.b, act.rtd, act.wreg, act.rw, act.mr, act.mw, act.valid, act.ill,
                     e.alu, e.a, e.b, e.rtd, e.wreg, e.rw, e.mr, e.mw, e.valid, e.ill);
        end
    endtask

    vec_t vecs[16];
    exp_t ill_e;
    exp_t add_e;
    exp_t cur;
    logic [5:0] op_pool[18];
    logic [5:0] fn_pool[8];

    initial begin
        tests = 0;
        failed = 0;
        build_rules();
        ill_e = mkexp(5'h00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1);
        add_e = mkexp(5'h00, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0);

        vecs[0]  = '{"add",     32'h00221820, 32'd5,        32'd7,        add_e};
        vecs[1]  = '{"sra",     32'h000520C3, 32'h11,       32'h80000000, mkexp(5'h12, 32'd3, 32'h80000000, 32'h80000000, 5'd4, 1, 0, 0, 0)};
        vecs[2]  = '{"lui",     32'h3C061234, 32'hDEAD,     32'h55,       mkexp(5'h10, 32'd16, 32'h1234, 32'h55, 5'd6, 1, 0, 0, 0)};
        vecs[3]  = '{"addi_m1", 32'h2022FFFF, 32'h100,      32'h9,        mkexp(5'h00, 32'h100, 32'hFFFFFFFF, 32'h9, 5'd2, 1, 0, 0, 0)};
        vecs[4]  = '{"ori",     32'h3422FFFF, 32'hF0F0,     32'h3,        mkexp(5'h08, 32'hF0F0, 32'h0000FFFF, 32'h3, 5'd2, 1, 0, 0, 0)};
        vecs[5]  = '{"bltz",    32'h04200010, 32'h80000000, 32'h44,       mkexp(5'h0F, 32'h80000000, 32'h0, 32'h44, 5'd0, 0, 0, 0, 0)};
        vecs[6]  = '{"jr",      32'h03E00008, 32'h400100,   32'h66,       mkexp(5'h09, 32'h400100, 32'h0, 32'h66, 5'd0, 0, 0, 0, 0)};
        vecs[7]  = '{"lw_r0",   32'h8C200004, 32'h1000,     32'h77,       mkexp(5'h00, 32'h1000, 32'h4, 32'h77, 5'd0, 0, 1, 0, 0)};
        vecs[8]  = '{"sw",      32'hAC220008, 32'h2000,     32'hCAFE,     mkexp(5'h00, 32'h2000, 32'h8, 32'hCAFE, 5'd0, 0, 0, 1, 0)};
        vecs[9]  = '{"ill_3f",  32'hFC000000, 32'h12,       32'h34,       ill_e};
        vecs[10] = '{"ill_rt5", 32'h04250000, 32'h12,       32'h34,       ill_e};
        vecs[11] = '{"bgez",    32'h04610000, 32'h7,        32'h1,        mkexp(5'h0C, 32'h7, 32'h0, 32'h1, 5'd0, 0, 0, 0, 0)};
        vecs[12] = '{"sllv",    32'h01283804, 32'hFFFFFF25, 32'h1,        mkexp(5'h10, 32'd5, 32'h1, 32'h1, 5'd7, 1, 0, 0, 0)};
        vecs[13] = '{"slti",    32'h28448000, 32'hFFFFFFFE, 32'h0,        mkexp(5'h13, 32'hFFFFFFFE, 32'hFFFF8000, 32'h0, 5'd4, 1, 0, 0, 0)};
        vecs[14] = '{"sub_r0",  32'h00220022, 32'h9,        32'h4,        mkexp(5'h05, 32'h9, 32'h4, 32'h4, 5'd0, 0, 0, 0, 0)};
        vecs[15] = '{"andi",    32'h30258001, 32'hFFFFFFFF, 32'h2,        mkexp(5'h06, 32'hFFFFFFFF, 32'h00008001, 32'h2, 5'd5, 1, 0, 0, 0)};

        // Reset held across edges with live inputs: outputs stay cleared.
        rst_n = 1'b0;
        drive(32'h00221820, 1, 32'd5, 32'd7, 0, 0);
        #22;
        check("reset_state", '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("first_after_reset", add_e);

        foreach (vecs[i]) begin
            drive(vecs[i].ins, 1, vecs[i].rs, vecs[i].rt, 0, 0);
            tick();
            check(vecs[i].name, vecs[i].e);
        end

        // Asynchronous reset between edges.
        drive(32'h00221820, 1, 32'd5, 32'd7, 0, 0);
        tick();
        #3 rst_n = 1'b0;
        #1 check("async_reset", '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("reload_after_async_reset", add_e);

        // Stall for 3 cycles with changing inputs.
        for (int k = 0; k < 3; k++) begin
            drive(vecs[k + 1].ins, 1, vecs[k + 1].rs, vecs[k + 1].rt, 1, 0);
            tick();
            check("stall_hold", add_e);
        end

        // Reset mid-stall, then the first edge after release loads normally.
        #2 rst_n = 1'b0;
        #1 check("reset_mid_stall", '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[8].ins, 1, vecs[8].rs, vecs[8].rt, 0, 0);
        tick();
        check("load_after_stall_reset", vecs[8].e);

        drive(vecs[2].ins, 1, vecs[2].rs, vecs[2].rt, 1, 1);
        tick();
        check("stall_and_flush", '0);

        drive(vecs[0].ins, 1, vecs[0].rs, vecs[0].rt, 0, 0);
        tick();
        drive(vecs[4].ins, 1, vecs[4].rs, vecs[4].rt, 0, 1);
        tick();
        check("flush_alone", '0);
        drive(vecs[4].ins, 1, vecs[4].rs, vecs[4].rt, 0, 0);
        tick();
        check("load_after_flush", vecs[4].e);

        drive(vecs[9].ins, 1, 32'h1, 32'h2, 0, 0);
        tick();
        check("illegal", ill_e);
        drive(vecs[0].ins, 1, vecs[0].rs, vecs[0].rt, 0, 0);
        tick();
        check("illegal_cleared", add_e);

        drive(vecs[0].ins, 0, vecs[0].rs, vecs[0].rt, 0, 0);
        tick();
        check("valid_low_bubble", '0);

        // Randomized traffic against the rule-table model.
        op_pool = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                    6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fn_pool = '{6'h20, 6'h22, 6'h25, 6'h27, 6'h2A, 6'h03, 6'h06, 6'h08};
        cur = '0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins, rsd, rtd;
            logic v, st, fl;
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[31:26] = op_pool[$urandom_range(0, 17)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = fn_pool[$urandom_range(0, 7)];
            if (ins[31:26] == 6'h01 && $urandom_range(0, 3) != 0) ins[20:16] = 5'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ins[15:11] = 5'd0;
            rsd = $urandom;
            rtd = $urandom;
            v  = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 6) == 0);
            fl = (n == 0) || ($urandom_range(0, 11) == 0);
            if (fl)       cur = '0;
            else if (!st) cur = model(ins, v, rsd, rtd);
            exp_q.push_back(cur);
            drive(ins, v, rsd, rtd, st, fl);
            tick();
            check("random", exp_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
